speed_ctrl: RTL and testbench

SPEED_CTRL -- requirements
Module: speed_ctrl

---
 rtl/speed_pkg.sv | 25 ++
 rtl/key_press_det.sv | 22 ++
 rtl/speed_ctrl.sv | 90 +++++++++
 tb/tb_speed_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared constants and types for the step-rate controller.
package speed_pkg;

    localparam int unsigned CNT_W = 32;
    localparam logic [2:0] LEVEL_MAX = 3'd4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    // Step period for a level: clock frequency halved per level, never below one cycle.
    function automatic logic [CNT_W-1:0] period_of(input logic [CNT_W-1:0] freq,
                                                    input logic [2:0]       lvl);
        logic [CNT_W-1:0] p;
        p = freq >> lvl;
        if (p == {CNT_W{1'b0}}) begin
            p = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            p = p;
        end
        return p;
    endfunction

endpackage

// File: rtl/key_press_det.sv
// Falling-edge press detector for one debounced active-low key.
module key_press_det (
    input  logic clk,
    input  logic rst_n,
    input  logic status,
    output logic press
);

    logic prev_r;

    // Previous key level; reset to released so a key held through reset counts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= status;
        end
    end

    assign press = prev_r & ~status;

endmodule

// File: rtl/speed_ctrl.sv
// Run/pause and speed-level control producing a periodic single-cycle step pulse.
module speed_ctrl
    import speed_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int LEVEL_DEFAULT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_status,
    input  logic       spdup_status,
    input  logic       spddn_status,
    output logic       paused,
    output logic [2:0] speed_level,
    output logic       step
);

    localparam logic [CNT_W-1:0] FREQ_W     = CNT_W'(CLK_FREQ);
    localparam logic [2:0]       LEVEL_INIT = 3'(LEVEL_DEFAULT);

    state_t           state_r, state_s;
    logic [2:0]       level_r, level_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] period_s;
    logic             lvl_chg_s;
    logic             pause_press_s, up_press_s, dn_press_s;

    key_press_det u_pause (.clk(clk), .rst_n(rst_n), .status(pause_status), .press(pause_press_s));
    key_press_det u_spdup (.clk(clk), .rst_n(rst_n), .status(spdup_status), .press(up_press_s));
    key_press_det u_spddn (.clk(clk), .rst_n(rst_n), .status(spddn_status), .press(dn_press_s));

    assign period_s = period_of(FREQ_W, level_r);

    // Next state, level and counter; the counter only advances while RUN persists across the edge.
    always_comb begin
        state_s   = state_r;
        level_s   = level_r;
        cnt_s     = cnt_r;
        lvl_chg_s = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (pause_press_s) state_s = ST_PAUSE;
                else               state_s = ST_RUN;
            end
            ST_PAUSE: begin
                if (pause_press_s) state_s = ST_RUN;
                else               state_s = ST_PAUSE;
            end
            default: state_s = ST_RUN;
        endcase

        if (up_press_s && !dn_press_s && (level_r < LEVEL_MAX)) begin
            level_s   = level_r + 3'd1;
            lvl_chg_s = 1'b1;
        end else if (dn_press_s && !up_press_s && (level_r != 3'd0)) begin
            level_s   = level_r - 3'd1;
            lvl_chg_s = 1'b1;
        end else begin
            level_s   = level_r;
        end

        if (lvl_chg_s) begin
            cnt_s = {CNT_W{1'b0}};
        end else if ((state_r == ST_RUN) && (state_s == ST_RUN)) begin
            if (cnt_r >= (period_s - 32'd1)) cnt_s = {CNT_W{1'b0}};
            else                             cnt_s = cnt_r + 32'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, level and period counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            level_r <= LEVEL_INIT;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            level_r <= level_s;
            cnt_r   <= cnt_s;
        end
    end

    assign paused      = (state_r == ST_PAUSE);
    assign speed_level = level_r;
    assign step        = rst_n & (state_r == ST_RUN) & (cnt_r == (period_s - 32'd1));

endmodule

// File: tb/tb_speed_ctrl.sv
// Directed scoreboard bench for speed_ctrl with a 16 Hz clock model (periods 16/8/4/2/1).
module tb_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause_status, spdup_status, spddn_status;
    logic       paused;
    logic [2:0] speed_level;
    logic       step;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic       step;
        logic       paused;
        logic [2:0] lvl;
    } exp_t;

    exp_t sb[$];

    speed_ctrl #(.CLK_FREQ(16), .LEVEL_DEFAULT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .pause_status(pause_status), .spdup_status(spdup_status), .spddn_status(spddn_status),
        .paused(paused), .speed_level(speed_level), .step(step)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            $error("check %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Queue the expectation for the current cycle, compare mid-cycle, advance to the next cycle.
    task automatic chk(input string tag, input logic e_step, input logic e_paused, input logic [2:0] e_lvl);
        exp_t e;
        e.tag = tag; e.step = e_step; e.paused = e_paused; e.lvl = e_lvl;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        cmp({e.tag, ".step"},   {2'b00, step},   {2'b00, e.step});
        cmp({e.tag, ".paused"}, {2'b00, paused}, {2'b00, e.paused});
        cmp({e.tag, ".level"},  speed_level,     e.lvl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag, input logic old_p, input logic [2:0] old_l);
        rst_n = 1'b0;
        chk(tag, 1'b0, old_p, old_l);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pause_status = 1'b1; spdup_status = 1'b1; spddn_status = 1'b1;
        @(posedge clk);
        #1;
        chk("reset", 1'b0, 1'b0, 3'd2);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) chk("rel_cadence", (k % 4) == 0, 1'b0, 3'd2);

        // speed-up to saturation
        spdup_status = 1'b0; chk("up_press1", 1'b0, 1'b0, 3'd2); spdup_status = 1'b1;
        chk("up_l3_c0", 1'b0, 1'b0, 3'd3);
        chk("up_l3_c1", 1'b1, 1'b0, 3'd3);
        spdup_status = 1'b0; chk("up_press2", 1'b0, 1'b0, 3'd3); spdup_status = 1'b1;
        chk("up_l4", 1'b1, 1'b0, 3'd4);
        spdup_status = 1'b0; chk("up_press3", 1'b1, 1'b0, 3'd4); spdup_status = 1'b1;
        for (int k = 0; k < 4; k++) chk("up_l4_sat", 1'b1, 1'b0, 3'd4);

        // speed-down to saturation
        do_reset("rst_a", 1'b0, 3'd4);
        spddn_status = 1'b0; chk("dn_press1", 1'b0, 1'b0, 3'd2); spddn_status = 1'b1;
        for (int k = 0; k < 3; k++) chk("dn_l1", 1'b0, 1'b0, 3'd1);
        spddn_status = 1'b0; chk("dn_press2", 1'b0, 1'b0, 3'd1); spddn_status = 1'b1;
        for (int j = 0; j < 16; j++) chk("dn_l0_period", j == 15, 1'b0, 3'd0);
        for (int j = 0; j < 5; j++) chk("dn_l0", 1'b0, 1'b0, 3'd0);
        spddn_status = 1'b0; chk("dn_press3_sat", 1'b0, 1'b0, 3'd0); spddn_status = 1'b1;
        for (int j = 0; j < 10; j++) chk("dn_l0_keep", j == 9, 1'b0, 3'd0);

        // pause with counter at 1, hold, resume
        do_reset("rst_b", 1'b0, 3'd0);
        chk("p_c0", 1'b0, 1'b0, 3'd2);
        pause_status = 1'b0; chk("p_press", 1'b0, 1'b0, 3'd2); pause_status = 1'b1;
        for (int k = 0; k < 50; k++) chk("p_hold", 1'b0, 1'b1, 3'd2);
        pause_status = 1'b0; chk("p_resume_press", 1'b0, 1'b1, 3'd2); pause_status = 1'b1;
        chk("p_r0", 1'b0, 1'b0, 3'd2);
        chk("p_r1", 1'b0, 1'b0, 3'd2);
        chk("p_r2_step", 1'b1, 1'b0, 3'd2);

        // simultaneous up/down cancels and leaves the cadence alone
        chk("sim_c0", 1'b0, 1'b0, 3'd2);
        spdup_status = 1'b0; spddn_status = 1'b0;
        chk("sim_press", 1'b0, 1'b0, 3'd2);
        spdup_status = 1'b1; spddn_status = 1'b1;
        for (int k = 0; k < 8; k++) chk("sim_cadence", (k == 1) || (k == 5), 1'b0, 3'd2);

        // pause and speed-up together, then speed-up while paused, then reset mid-operation
        pause_status = 1'b0; spdup_status = 1'b0;
        chk("pu_press", 1'b0, 1'b0, 3'd2);
        pause_status = 1'b1; spdup_status = 1'b1;
        chk("pu_paused_l3", 1'b0, 1'b1, 3'd3);
        spdup_status = 1'b0; chk("pu_up_in_pause", 1'b0, 1'b1, 3'd3); spdup_status = 1'b1;
        chk("pu_l4", 1'b0, 1'b1, 3'd4);
        do_reset("rst_mid", 1'b1, 3'd4);
        for (int k = 1; k <= 4; k++) chk("mid_rel", k == 4, 1'b0, 3'd2);

        // key held low through reset counts as one press after release
        spdup_status = 1'b0; rst_n = 1'b0;
        chk("rst_pending", 1'b0, 1'b0, 3'd2);
        rst_n = 1'b1;
        chk("held_press", 1'b0, 1'b0, 3'd2);
        spdup_status = 1'b1;
        chk("held_l3", 1'b0, 1'b0, 3'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
